// File: rtl/find_global_bkt_lvl_if.sv
// -----------------------------------------------------------------------------
// find_global_bkt_lvl_if
// Bundles the controller handshake and level-table access signals of the
// global backtrack-level search stage.
//   master : controller / level-table side (drives start, core level, rd data)
//   slave  : search stage (drives done/busy, results, rd/wr strobes)
// Signal names keep the stage-relative _i/_o suffixes.
// -----------------------------------------------------------------------------
interface find_global_bkt_lvl_if #(
   parameter int WIDTH_BIN_ID = 10,
   parameter int WIDTH_LVL    = 16
);
   logic                    start_find_i;
   logic [WIDTH_LVL-1:0]    bkt_lvl_from_core_i;
   logic                    done_find_o;
   logic                    busy_o;
   logic [WIDTH_LVL-1:0]    bkt_lvl_o;
   logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
   logic                    lvl_rd_en_o;
   logic [WIDTH_LVL-1:0]    lvl_rd_addr_o;
   logic [WIDTH_BIN_ID:0]   lvl_rd_data_i;
   logic                    lvl_wr_en_o;
   logic [WIDTH_LVL-1:0]    lvl_wr_addr_o;
   logic [WIDTH_BIN_ID:0]   lvl_wr_data_o;

   modport master (
      output start_find_i, bkt_lvl_from_core_i, lvl_rd_data_i,
      input  done_find_o, busy_o, bkt_lvl_o, bkt_bin_o,
             lvl_rd_en_o, lvl_rd_addr_o, lvl_wr_en_o, lvl_wr_addr_o, lvl_wr_data_o
   );

   modport slave (
      input  start_find_i, bkt_lvl_from_core_i, lvl_rd_data_i,
      output done_find_o, busy_o, bkt_lvl_o, bkt_bin_o,
             lvl_rd_en_o, lvl_rd_addr_o, lvl_wr_en_o, lvl_wr_addr_o, lvl_wr_data_o
   );
endinterface

// File: rtl/find_global_bkt_lvl.sv
// -----------------------------------------------------------------------------
// find_global_bkt_lvl
// Scans the global level table downward from the core's backtrack level,
// finds the highest level whose decision is not yet flipped, marks it flipped
// and returns {level, owning bin}. A returned bin of 0 means global UNSAT.
//
// Ports:
//   clk   : clock
//   rst   : synchronous, active-low reset
//   bus   : find_global_bkt_lvl_if.slave
//           start_find_i / bkt_lvl_from_core_i : start pulse + requested level
//           done_find_o / busy_o               : completion pulse, busy flag
//           bkt_lvl_o / bkt_bin_o              : result, held until next done
//           lvl_rd_*  : table read, data valid the cycle after lvl_rd_en_o
//           lvl_wr_*  : table write, data format {dcd_bin, has_bkt}
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start_find_i
// S_READ  | read strobe for level r_lvl is on the table port
// S_CHECK | table data for r_lvl is valid; decide found / skip / UNSAT
// S_WRITE | write strobe marking r_lvl as flipped
// S_DONE  | one-cycle completion pulse, results valid
// -----------------------------------------------------------------------------
module find_global_bkt_lvl #(
   parameter int WIDTH_BIN_ID = 10,
   parameter int WIDTH_LVL    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   find_global_bkt_lvl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [WIDTH_LVL-1:0] LVL_ONE = WIDTH_LVL'(1);

   state_t                  r_state, w_state_nxt;
   logic [WIDTH_LVL-1:0]    r_lvl, w_lvl_nxt;
   logic [WIDTH_BIN_ID-1:0] r_bin, w_bin_nxt;
   logic [WIDTH_LVL-1:0]    w_res_lvl;
   logic [WIDTH_BIN_ID-1:0] w_res_bin;

   logic                    w_has_bkt;
   logic [WIDTH_BIN_ID-1:0] w_dcd_bin;

   logic                    w_rd_en, w_wr_en, w_done, w_busy;

   logic                    r_done, r_busy, r_rd_en, r_wr_en;
   logic [WIDTH_LVL-1:0]    r_bkt_lvl, r_rd_addr, r_wr_addr;
   logic [WIDTH_BIN_ID-1:0] r_bkt_bin;
   logic [WIDTH_BIN_ID:0]   r_wr_data;

   assign w_has_bkt = bus.lvl_rd_data_i[0];
   assign w_dcd_bin = bus.lvl_rd_data_i[WIDTH_BIN_ID:1];

   // All outputs are registered: they are computed from the next state so the
   // strobes line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_lvl     <= '0;
         r_bin     <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_bkt_lvl <= '0;
         r_bkt_bin <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lvl     <= w_lvl_nxt;
         r_bin     <= w_bin_nxt;
         r_done    <= w_done;
         r_busy    <= w_busy;
         r_rd_en   <= w_rd_en;
         r_rd_addr <= w_rd_en ? w_lvl_nxt : '0;
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_en ? w_lvl_nxt : '0;
         r_wr_data <= w_wr_en ? {w_bin_nxt, 1'b1} : '0;
         if (w_done) begin
            r_bkt_lvl <= w_res_lvl;
            r_bkt_bin <= w_res_bin;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lvl_nxt   = r_lvl;
      w_bin_nxt   = r_bin;
      w_res_lvl   = '0;
      w_res_bin   = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.start_find_i) begin
               w_lvl_nxt   = bus.bkt_lvl_from_core_i;
               w_state_nxt = (bus.bkt_lvl_from_core_i == '0) ? S_DONE : S_READ;
            end
         end
         S_READ:  w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (!w_has_bkt) begin
               w_bin_nxt   = w_dcd_bin;
               w_state_nxt = S_WRITE;
            end else if (r_lvl <= LVL_ONE) begin
               // every level down to 1 already flipped: global UNSAT
               w_state_nxt = S_DONE;
            end else begin
               w_lvl_nxt   = r_lvl - LVL_ONE;
               w_state_nxt = S_READ;
            end
         end
         S_WRITE: begin
            w_res_lvl   = r_lvl;
            w_res_bin   = r_bin;
            w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_en = (w_state_nxt == S_READ);
      w_wr_en = (w_state_nxt == S_WRITE);
      w_done  = (w_state_nxt == S_DONE);
      w_busy  = (w_state_nxt != S_IDLE);
   end

   assign bus.done_find_o   = r_done;
   assign bus.busy_o        = r_busy;
   assign bus.bkt_lvl_o     = r_bkt_lvl;
   assign bus.bkt_bin_o     = r_bkt_bin;
   assign bus.lvl_rd_en_o   = r_rd_en;
   assign bus.lvl_rd_addr_o = r_rd_addr;
   assign bus.lvl_wr_en_o   = r_wr_en;
   assign bus.lvl_wr_addr_o = r_wr_addr;
   assign bus.lvl_wr_data_o = r_wr_data;

endmodule

// File: tb/tb_find_global_bkt_lvl.sv
module tb_find_global_bkt_lvl;
   localparam int WB = 10;
   localparam int WL = 16;

   typedef struct {
      int req;
      int lvl;
      int bin;
      int cyc;
      int rds;
      int wrs;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   find_global_bkt_lvl_if #(.WIDTH_BIN_ID(WB), .WIDTH_LVL(WL)) bus ();

   find_global_bkt_lvl #(.WIDTH_BIN_ID(WB), .WIDTH_LVL(WL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Level table seen by the DUT, plus a preload port owned by the stimulus.
   logic [WB:0] mem [0:63];
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [WB:0] ld_data;

   always @(posedge clk) begin
      if (bus.lvl_rd_en_o) bus.lvl_rd_data_i <= mem[bus.lvl_rd_addr_o[5:0]];
      if (bus.lvl_wr_en_o) mem[bus.lvl_wr_addr_o[5:0]] <= bus.lvl_wr_data_o;
      if (ld_en) mem[ld_addr] <= ld_data;
   end

   // Reference table: what the level table should contain after each search.
   logic [WB:0] model_tbl [0:63];
   exp_t        sb [$];
   logic        allow_stray_rd = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic prev_rst = 1'b1;
   int   rd_cnt = 0, wr_cnt = 0;
   logic hold_chk = 1'b0;
   int   last_lvl = 0, last_bin = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (!prev_rst) begin
            chk("rst_done",    64'(bus.done_find_o),   0);
            chk("rst_busy",    64'(bus.busy_o),        0);
            chk("rst_lvl",     64'(bus.bkt_lvl_o),     0);
            chk("rst_bin",     64'(bus.bkt_bin_o),     0);
            chk("rst_rd_en",   64'(bus.lvl_rd_en_o),   0);
            chk("rst_rd_addr", 64'(bus.lvl_rd_addr_o), 0);
            chk("rst_wr_en",   64'(bus.lvl_wr_en_o),   0);
            chk("rst_wr_addr", 64'(bus.lvl_wr_addr_o), 0);
            chk("rst_wr_data", 64'(bus.lvl_wr_data_o), 0);
         end
         rd_cnt   = 0;
         wr_cnt   = 0;
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            chk("done_pulse_width", 64'(bus.done_find_o), 0);
            chk("hold_lvl", 64'(bus.bkt_lvl_o), 64'(last_lvl));
            chk("hold_bin", 64'(bus.bkt_bin_o), 64'(last_bin));
            hold_chk = 1'b0;
         end
         if (bus.lvl_rd_en_o) begin
            chk("rd_wr_overlap", 64'(bus.lvl_wr_en_o), 0);
            if (sb.size() != 0)
               chk("rd_addr", 64'(bus.lvl_rd_addr_o), 64'(sb[0].req - rd_cnt));
            else if (!allow_stray_rd)
               chk("rd_unexpected", 64'(bus.lvl_rd_en_o), 0);
            rd_cnt++;
         end
         if (bus.lvl_wr_en_o) begin
            if (sb.size() != 0) begin
               chk("wr_addr", 64'(bus.lvl_wr_addr_o), 64'(sb[0].lvl));
               chk("wr_data", 64'(bus.lvl_wr_data_o), 64'((sb[0].bin << 1) | 1));
            end else begin
               chk("wr_unexpected", 64'(bus.lvl_wr_en_o), 0);
            end
            wr_cnt++;
         end
         if (bus.done_find_o) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", 64'(bus.done_find_o), 0);
            end else begin
               e = sb.pop_front();
               chk("res_lvl",    64'(bus.bkt_lvl_o), 64'(e.lvl));
               chk("res_bin",    64'(bus.bkt_bin_o), 64'(e.bin));
               chk("done_cycle", 64'(cyc),           64'(e.cyc));
               chk("num_reads",  64'(rd_cnt),        64'(e.rds));
               chk("num_writes", 64'(wr_cnt),        64'(e.wrs));
               chk("busy_in_done", 64'(bus.busy_o),  1);
               last_lvl = e.lvl;
               last_bin = e.bin;
               hold_chk = 1'b1;
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end else if (sb.size() != 0 && cyc > sb[0].cyc + 16) begin
            chk("done_timeout", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
      prev_rst = rst;
   end

   // ---------------- reference model ----------------
   // Walk the table from the requested level down; first unflipped level wins
   // and becomes flipped. Latency: found at k-th read -> 2k+2, all n flipped
   // -> 2n+1, request 0 -> 1.
   task automatic model_find(input int req, input int c0, output exp_t e);
      int found = 0;
      e.req = req; e.lvl = 0; e.bin = 0; e.rds = 0; e.wrs = 0;
      for (int l = req; l >= 1 && found == 0; l--) begin
         e.rds++;
         if (model_tbl[l][0] == 1'b0) begin
            found = 1;
            e.lvl = l;
            e.bin = int'(model_tbl[l][WB:1]);
            e.wrs = 1;
            model_tbl[l][0] = 1'b1;
         end
      end
      if (req == 0)   e.cyc = c0 + 1;
      else if (found) e.cyc = c0 + 2 * e.rds + 2;
      else            e.cyc = c0 + 2 * req + 1;
   endtask

   // ---------------- stimulus ----------------
   task automatic load(input int l, input logic has, input logic [WB-1:0] bin);
      model_tbl[l] = {bin, has};
      ld_en   = 1'b1;
      ld_addr = 6'(l);
      ld_data = {bin, has};
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   task automatic fill_random(input int pct_flipped);
      for (int l = 0; l < 64; l++)
         load(l, ($urandom_range(0, 99) < pct_flipped) ? 1'b1 : 1'b0, WB'($urandom_range(1, 1023)));
   endtask

   task automatic pulse_start(input int req);
      bus.start_find_i        = 1'b1;
      bus.bkt_lvl_from_core_i = WL'(req);
      @(negedge clk);
      bus.start_find_i        = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_find(input int req, input int extra_req, input int gap);
      exp_t e;
      model_find(req, cyc, e);
      sb.push_back(e);
      pulse_start(req);
      if (gap > 0) begin
         repeat (gap - 1) @(negedge clk);
         pulse_start(extra_req);
      end
      wait_idle();
   endtask

   initial begin
      rst = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      bus.start_find_i = 1'b0;
      bus.bkt_lvl_from_core_i = '0;
      bus.lvl_rd_data_i = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      fill_random(100);

      // found at first read
      load(3, 1'b0, 10'd5);
      run_find(3, 0, 0);
      // two skips then found at level 2
      load(4, 1'b1, 10'd9);
      load(3, 1'b1, 10'd5);
      load(2, 1'b0, 10'd2);
      run_find(4, 0, 0);
      // everything flipped: UNSAT
      load(2, 1'b1, 10'd2);
      load(1, 1'b1, 10'd1);
      run_find(2, 0, 0);
      // requested level 0
      run_find(0, 0, 0);

      // reset during CHECK aborts the search
      load(5, 1'b0, 10'd7);
      allow_stray_rd = 1'b1;
      pulse_start(5);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      allow_stray_rd = 1'b0;
      @(negedge clk);
      run_find(5, 0, 0);

      // second start while busy is ignored
      load(6, 1'b1, 10'd3);
      load(5, 1'b0, 10'd11);
      run_find(6, 9, 2);

      // randomized searches
      for (int t = 0; t < 48; t++) begin
         int req, gap;
         if (t % 8 == 0) fill_random($urandom_range(30, 80));
         req = $urandom_range(0, 24);
         gap = (req > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         run_find(req, $urandom_range(0, 40), gap);
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/find_global_bkt_lvl.md
# find_global_bkt_lvl

Global backtrack-level search stage, started by the bin-manager controller when a bin's core run ends locally UNSAT. It scans the global level table downward from the core's requested backtrack level. It finds the highest level whose decision has not yet been flipped, marks that level as flipped, and returns the level and the bin that owns it. A returned bin of 0 signals global UNSAT to the controller.

## Interface
- WIDTH_BIN_ID, 10, bin identifier width; bin 0 is reserved and means "no bin".
- WIDTH_LVL, 16, decision-level width; also the level-table address width.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start_find_i  in  1  one-cycle start pulse from the controller.
- bkt_lvl_from_core_i  in  WIDTH_LVL  backtrack level requested by the core; sampled on start.
- done_find_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in every state except IDLE.
- bkt_lvl_o  out  WIDTH_LVL  resulting global backtrack level.
- bkt_bin_o  out  WIDTH_BIN_ID  bin owning bkt_lvl_o; 0 means global UNSAT.
- lvl_rd_en_o  out  1  level-table read enable.
- lvl_rd_addr_o  out  WIDTH_LVL  level-table read address (the level).
- lvl_rd_data_i  in  WIDTH_BIN_ID+1  read data, valid the cycle after lvl_rd_en_o. Bit 0 is has_bkt; bits [WIDTH_BIN_ID:1] are dcd_bin.
- lvl_wr_en_o  out  1  level-table write enable.
- lvl_wr_addr_o  out  WIDTH_LVL  write address.
- lvl_wr_data_o  out  WIDTH_BIN_ID+1  write data, same format as the read data.

## Operation
- States: IDLE, READ, CHECK, WRITE, DONE.
- Internal registers: lvl_r (WIDTH_LVL) and bin_r (WIDTH_BIN_ID).
- IDLE:
  - On start_find_i, latch lvl_r = bkt_lvl_from_core_i.
  - If the latched value is 0, go to DONE with result lvl 0, bin 0. No table access is made.
  - Otherwise go to READ.
  - When start_find_i is low, stay in IDLE.
- READ: assert lvl_rd_en_o=1 with lvl_rd_addr_o=lvl_r, then go to CHECK.
- CHECK: lvl_rd_data_i is valid in this state.
  - If has_bkt==0: latch bin_r = dcd_bin and go to WRITE.
  - If has_bkt==1 and lvl_r==1: result is lvl 0, bin 0; go to DONE.
  - If has_bkt==1 and lvl_r>1: decrement lvl_r by 1 and go to READ.
- WRITE: assert lvl_wr_en_o=1 with lvl_wr_addr_o=lvl_r and lvl_wr_data_o={bin_r,1'b1}. Result is lvl lvl_r, bin bin_r. Go to DONE.
- DONE: assert done_find_o=1 for exactly this cycle, then go to IDLE.
- Result registers:
  - bkt_lvl_o and bkt_bin_o load on entry to DONE.
  - They hold until the next entry to DONE, so they are valid together with done_find_o and afterwards.
- lvl_r never decrements below 1; there is no wrap-around.
- A found entry with dcd_bin==0 is a malformed table entry. It is passed through unchanged and not checked.
- start_find_i is ignored outside IDLE. A start in the DONE cycle is lost.
- Read and write never occur in the same cycle.

## Timing
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: done_find_o, busy_o, bkt_lvl_o, bkt_bin_o, lvl_rd_en_o, lvl_rd_addr_o, lvl_wr_en_o, lvl_wr_addr_o, lvl_wr_data_o.
  - A reset mid-search aborts the search: no write is issued and no done pulse follows.
- Cycle numbering: the start pulse is in cycle 0.
  - Level found at the first level read: READ in cycle 1, CHECK in cycle 2, WRITE in cycle 3, done_find_o in cycle 4.
  - Each additional level skipped adds 2 cycles. Found at the k-th level read: done_find_o in cycle 2k+2.
  - All n levels flipped (UNSAT): done_find_o in cycle 2n+1.
  - Requested level 0: done_find_o in cycle 1.
- All outputs are registered. Table read/write strobes are single-cycle pulses.

## Test plan
- Requested level 3; table: L3 has_bkt=0, dcd_bin=5. Required: read L3, write L3={5,1}, done_find_o in cycle 4, bkt_lvl_o=3, bkt_bin_o=5.
- Requested level 4; table: L4 and L3 have has_bkt=1; L2 has has_bkt=0, dcd_bin=2. Required: reads at L4, L3, L2; one write to L2; done_find_o in cycle 8; outputs 2/2.
- Requested level 2; L2 and L1 both have has_bkt=1. Required: no write; done_find_o in cycle 5; bkt_lvl_o=0, bkt_bin_o=0.
- Requested level 0. Required: no table access; done_find_o in cycle 1; outputs 0/0.
- rst driven to 0 during CHECK. Required: all outputs 0 next cycle; no write and no done pulse. A fresh start afterwards completes normally.
- Second start_find_i pulse while busy_o=1. Required: ignored; exactly one done_find_o pulse, with results unchanged.
